// File: rtl/acc_mem_feeder.sv
// Sequencer that streams N memory entries into the accumulator and captures the final sum.
// Reads are issued back-to-back; the 1-cycle memory latency is absorbed by a registered valid.
module acc_mem_feeder #(
  parameter int unsigned AWIDTH        = 8,
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [AWIDTH-1:0]        base_addr_i,
  input  logic [AWIDTH:0]          num_cnt_i,
  output logic                     mem_ce_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] mem_data_i,
  output logic                     acc_run_o,
  output logic                     acc_valid_o,
  output logic [IN_DATA_WIDTH-1:0] acc_number_o,
  input  logic [DWIDTH-1:0]        acc_result_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic [AWIDTH:0]     cnt_q, cnt_d;
  logic [AWIDTH:0]     idx_q, idx_d;
  logic [AWIDTH:0]     idx_inc;
  logic                valid_q;
  logic                done_q, done_d;
  logic [DWIDTH-1:0]   result_q, result_d;
  logic                rd_en;
  logic                run_pulse;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    result_d  = result_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    run_pulse = 1'b0;
    idx_inc   = idx_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          cnt_d   = num_cnt_i;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // idx is zero only on the first RUN cycle of a job, including N=0.
        run_pulse = (idx_q == '0);
        if (idx_q < cnt_q) begin
          rd_en = 1'b1;
          idx_d = idx_inc;
          if (idx_inc == cnt_q) begin
            state_d = StDrain;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        result_d = acc_result_i;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      valid_q  <= rd_en;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Address arithmetic is AWIDTH bits wide so it wraps naturally at the top of memory.
  assign mem_ce_o     = rd_en;
  assign mem_addr_o   = rd_en ? (base_q + idx_q[AWIDTH-1:0]) : '0;
  assign acc_run_o    = run_pulse;
  assign acc_valid_o  = valid_q;
  assign acc_number_o = mem_data_i;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign result_o     = result_q;

endmodule

// File: tb/tb_acc_mem_feeder.sv
// Scoreboard bench for acc_mem_feeder with a 1-cycle memory and a behavioural accumulator.
module tb_acc_mem_feeder;
  localparam int AW = 8;
  localparam int IW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_cnt_i = '0;
  logic          mem_ce_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_data_i;
  logic          acc_run_o;
  logic          acc_valid_o;
  logic [IW-1:0] acc_number_o;
  logic [DW-1:0] acc_result_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;

  acc_mem_feeder #(.AWIDTH(AW), .IN_DATA_WIDTH(IW), .DWIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_cnt_i    (num_cnt_i),
    .mem_ce_o     (mem_ce_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .acc_run_o    (acc_run_o),
    .acc_valid_o  (acc_valid_o),
    .acc_number_o (acc_number_o),
    .acc_result_i (acc_result_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [0:255];
  logic [IW-1:0] mem_rd = '0;
  logic [DW-1:0] acc = '0;

  always @(posedge clk) if (mem_ce_o) mem_rd <= mem[mem_addr_o];
  assign mem_data_i = mem_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)         acc <= '0;
    else if (acc_run_o)   acc <= '0;
    else if (acc_valid_o) acc <= acc + DW'(acc_number_o);
  end
  assign acc_result_i = acc;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int addr_q[$];
  int num_q[$];
  int run_q[$];
  int done_q[$];
  int res_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (mem_ce_o) begin
        if (addr_q.size() == 0) chk("spurious_read", 1, 0);
        else chk("mem_addr", mem_addr_o, addr_q.pop_front());
      end
      if (acc_valid_o) begin
        chk("valid_with_run", acc_run_o, 0);
        if (num_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("acc_number", acc_number_o, num_q.pop_front());
      end
      if (acc_run_o) begin
        if (run_q.size() == 0) chk("spurious_run", 1, 0);
        else chk("run_cycle", cyc, run_q.pop_front());
      end
      if (done_o) begin
        if (done_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("result", result_o, res_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000; k++) begin
      if (!busy_o) break;
      @(negedge clk);
    end
    if (k == 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic push_job(input int c, input int base, input int n, input int res);
    run_q.push_back(c + 1);
    done_q.push_back(c + n + 3);
    res_q.push_back(res);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back((base + i) % 256);
      num_q.push_back(int'(mem[(base + i) % 256]));
    end
  endtask

  task automatic start_job(input int base, input int n, input int res);
    wait_idle();
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    num_cnt_i   = 9'(n);
    push_job(cyc, base, n, res);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      if (res_q.size() == 0 && addr_q.size() == 0 && num_q.size() == 0) break;
      @(posedge clk);
    end
    if (k == bound) begin
      chk("drain_timeout", 1, 0);
      addr_q.delete(); num_q.delete(); run_q.delete(); done_q.delete(); res_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    chk("rst_mem_ce", mem_ce_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_valid", acc_valid_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic sum
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    start_job(0, 4, 10);
    wait_drain(40);
    chk("hold_result", result_o, 10);

    // Zero count
    start_job(0, 0, 0);
    wait_drain(40);

    // Address wrap
    mem[254] = 8'd5; mem[255] = 8'd6; mem[0] = 8'd7; mem[1] = 8'd8;
    start_job(254, 4, 26);
    wait_drain(40);

    // Full depth
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    start_job(0, 256, 65280);
    wait_drain(300);

    // Back-to-back with start held high: accepted only in IDLE, period N+3
    mem[10] = 8'd3; mem[11] = 8'd4;
    wait_idle();
    c = cyc;
    start_i     = 1'b1;
    base_addr_i = AW'(10);
    num_cnt_i   = 9'(2);
    push_job(c, 10, 2, 7);
    push_job(c + 5, 10, 2, 7);
    push_job(c + 10, 10, 2, 7);
    repeat (11) @(posedge clk);
    #1 start_i = 1'b0;
    wait_drain(40);
    chk("b2b_result", result_o, 7);

    // Reset mid-run
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    wait_idle();
    c = cyc;
    start_i     = 1'b1;
    base_addr_i = '0;
    num_cnt_i   = 9'(8);
    run_q.push_back(c + 1);
    for (int i = 0; i < 3; i++) addr_q.push_back(i);
    num_q.push_back(1);
    num_q.push_back(2);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_mem_ce", mem_ce_o, 0);
    chk("abort_mem_addr", mem_addr_o, 0);
    chk("abort_run", acc_run_o, 0);
    chk("abort_valid", acc_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_pending", addr_q.size() + num_q.size() + run_q.size(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_abort_result", result_o, 0);

    mem[0] = 8'd9;
    start_job(0, 1, 9);
    wait_drain(40);

    repeat (5) @(negedge clk);
    chk("leftover", addr_q.size() + num_q.size() + run_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_mem_feeder.md
Name: acc_mem_feeder

Overview:
Upstream sequencer for the accumulator core. On a start pulse it streams N consecutive entries from a 1-cycle-latency on-chip memory into the accumulator, and drives the accumulator's clear (run) and valid/number inputs. After the last update has landed, it captures the accumulator's result and pulses done. It sits between the 256-entry data memory and the accumulator, and is driven by the top-level control.

Parameters:
AWIDTH, 8, memory address width; memory depth is 2^AWIDTH
IN_DATA_WIDTH, 8, memory data width; equals the accumulator operand width
DWIDTH, 16, accumulator result width; must be at least IN_DATA_WIDTH+AWIDTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  start request; sampled only in IDLE
base_addr_i  in  AWIDTH  first memory address; latched on accepted start
num_cnt_i  in  AWIDTH+1  element count N, range 0..2^AWIDTH; latched on accepted start
mem_ce_o  out  1  memory read enable
mem_addr_o  out  AWIDTH  memory read address
mem_data_i  in  IN_DATA_WIDTH  memory read data; valid 1 cycle after mem_ce_o
acc_run_o  out  1  accumulator clear pulse
acc_valid_o  out  1  accumulator operand valid
acc_number_o  out  IN_DATA_WIDTH  accumulator operand
acc_result_i  in  DWIDTH  accumulator result
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  1-cycle pulse when result_o is updated
result_o  out  DWIDTH  captured sum; holds its value until the next capture

Behaviour:
- Reset is asynchronous, active-low (reset_n), clock clk. Reset values: state=IDLE, all outputs 0, result_o=0, internal counters 0.
- Reset asserted mid-operation aborts immediately. There is no done_o pulse, and result_o is cleared to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches base_addr_i and num_cnt_i, clears the index, and moves to RUN.
  - start_i is ignored in every other state. There is no queueing.
- RUN:
  - First RUN cycle: acc_run_o=1 (exactly one cycle per job).
  - Every RUN cycle with idx<N: mem_ce_o=1, mem_addr_o=(base+idx) mod 2^AWIDTH, then idx increments.
  - Address wraps from 2^AWIDTH-1 to 0.
  - When the address for idx=N-1 is issued, next state is DRAIN.
  - N=0: the single RUN cycle asserts acc_run_o with mem_ce_o=0, and next state is DONE.
- DRAIN: one cycle, no read issued, then DONE.
- DONE: one cycle. At its closing edge, result_o<=acc_result_i, done_o<=1, and state goes to IDLE.
- Accumulator feed:
  - acc_valid_o is mem_ce_o delayed by one register stage.
  - acc_number_o = mem_data_i (combinational pass-through).
  - acc_valid_o is never high in the same cycle as acc_run_o.
- Timing for a start accepted in cycle 0 (N>=1):
  - acc_run_o in cycle 1.
  - Reads in cycles 1..N.
  - acc_valid_o in cycles 2..N+1.
  - DONE in cycle N+2.
  - done_o and the new result_o in cycle N+3.
  - busy_o is high in cycles 1..N+2.
- Timing for N=0: done_o in cycle 3, result_o=0.
- A new start_i is accepted in the cycle done_o is high (state is IDLE). Back-to-back jobs therefore have a period of N+3 cycles.
- num_cnt_i > 2^AWIDTH is out of range. The count register is still honoured modulo 2^(AWIDTH+1), with no clamp.
- No arithmetic is performed on data; width growth is handled by the accumulator.

Test Plan:
- Basic sum: mem[0..3]=1,2,3,4; start with base=0, N=4 at cycle 0 -> acc_run_o at cycle 1; acc_valid_o in cycles 2..5 with numbers 1,2,3,4; done_o at cycle 7; result_o=10.
- Address wrap: base=254, N=4, mem[254]=5, mem[255]=6, mem[0]=7, mem[1]=8 -> mem_addr_o sequence 254,255,0,1; result_o=26.
- Full depth: all 256 entries =0xFF, base=0, N=256 -> 256 acc_valid_o pulses; done_o at cycle 259; result_o=65280 (0xFF00), no overflow.
- Zero count: N=0 after a previous job with result 10 -> one acc_run_o pulse, no mem_ce_o, done_o at cycle 3, result_o=0.
- Busy/back-to-back: start_i held high continuously with N=2 -> starts accepted only in IDLE; jobs start every 5 cycles; a start pulse mid-RUN has no effect.
- Reset mid-run: N=8, reset_n low at cycle 4 -> all outputs 0 immediately, no done_o pulse; after release a fresh job with N=1, mem[0]=9 gives result_o=9.
